dmem_responder: RTL and testbench

- Memory-side responder for the CPU's data-memory port. It accepts load/store requests over a valid/ready handshake, checks alignment and range, and performs the access on an internal word-organised SRAM.
- On a store, it produces byte strobes and lane-aligned write data. On a load, it extracts the addressed byte/halfword/word and sign- or zero-extends it.
- It returns one response per request after a programmable number of wait states.
- It is the slave end of the load/store path and replaces the bare single-cycle DRAM for wait-state and misaligned-access testing.

---
 rtl/dmem_if.sv | 27 ++
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-memory port between the CPU load/store unit (master) and a memory
// responder (slave): a request channel and a response channel, each with its
// own valid/ready handshake.
interface dmem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_sl_type;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_sl_type, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_sl_type, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, checks type,
// alignment and range, performs the access on a word-organised array and
// returns a single response after WAIT_CYCLES wait states.
module dmem_responder #(
    parameter int DEPTH       = 65536,
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 32
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);
    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_next;
    logic [3:0]        wait_cnt;
    logic              accept, enter_resp;

    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [3:0]        cap_sl;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_sl;
    logic [1:0]        size;
    logic              req_err, mem_we;
    logic [IDX_W-1:0]  mem_idx;

    logic [3:0]        strb;
    logic [31:0]       lanes, rd_word, load_data;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [31:0]       mem [DEPTH];

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign accept        = bus.req_valid && (state == IDLE);

    // With no wait states the access happens on the accept edge itself, so the
    // live bus request is used in IDLE and the captured copy afterwards.
    assign cur_we    = (state == IDLE) ? bus.req_we      : cap_we;
    assign cur_addr  = (state == IDLE) ? bus.req_addr    : cap_addr;
    assign cur_wdata = (state == IDLE) ? bus.req_wdata   : cap_wdata;
    assign cur_sl    = (state == IDLE) ? bus.req_sl_type : cap_sl;

    assign size    = cur_sl[1:0];
    assign mem_idx = cur_addr[IDX_W+1:2];
    assign req_err = (size == 2'b11) || cur_sl[3]
                  || ((size == 2'b01) && cur_addr[0])
                  || ((size == 2'b10) && (cur_addr[1:0] != 2'b00))
                  || (64'(cur_addr[ADDR_W-1:2]) >= 64'(DEPTH));
    assign mem_we  = rst_n && enter_resp && cur_we && !req_err;
    assign rd_word = mem[mem_idx];

    // Next-state logic; the access strobe marks the edge that enters RESP.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        state_next = state;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (WAIT_CYCLES > 0) begin
                    state_next = WAIT;
                end else begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            WAIT: if (wait_cnt == 4'd0) begin
                state_next = RESP;
                enter_resp = 1'b1;
            end
            RESP: if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Store byte strobes and lane-replicated write data.
    always_comb begin
        strb  = 4'b1111;
        lanes = cur_wdata;
        case (size)
            2'b00: begin
                strb  = 4'b0001 << cur_addr[1:0];
                lanes = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                strb  = 4'b0011 << cur_addr[1:0];
                lanes = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction with sign or zero extension.
    always_comb begin
        byte_lane = 8'(rd_word >> {cur_addr[1:0], 3'b000});
        half_lane = 16'(rd_word >> {cur_addr[1], 4'b0000});
        load_data = rd_word;
        case (size)
            2'b00:   load_data = {{24{~cur_sl[2] & byte_lane[7]}}, byte_lane};
            2'b01:   load_data = {{16{~cur_sl[2] & half_lane[15]}}, half_lane};
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Request capture, wait counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= 4'd0;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cap_sl      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cap_we    <= bus.req_we;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
                cap_sl    <= bus.req_sl_type;
                wait_cnt  <= WAIT_INIT;
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_err_q   <= req_err;
                rsp_rdata_q <= (req_err || cur_we) ? 32'd0 : load_data;
            end
        end
    end

    // Strobed array write; only enabled bytes change.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately outside the reset; only control state is reset.
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem[mem_idx][8*b +: 8] <= lanes[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states), a directed
// vector table, hand-written latency/backpressure/reset sequences, and random
// traffic checked against a byte-addressed reference model.
module tb_dmem_responder;
    localparam int DEPTH = 65536;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sl;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    logic        rst_n       [2];
    logic        t_req_valid [2];
    logic        t_req_we    [2];
    logic [31:0] t_req_addr  [2];
    logic [31:0] t_req_wdata [2];
    logic [3:0]  t_req_sl    [2];
    logic        t_rsp_ready [2];
    logic        t_req_ready [2];
    logic        t_rsp_valid [2];
    logic [31:0] t_rsp_rdata [2];
    logic        t_rsp_err   [2];

    logic [7:0]  model [int];

    dmem_if #(.ADDR_W(32)) bus0 ();
    dmem_if #(.ADDR_W(32)) bus3 ();

    assign bus0.req_valid   = t_req_valid[0];
    assign bus0.req_we      = t_req_we[0];
    assign bus0.req_addr    = t_req_addr[0];
    assign bus0.req_wdata   = t_req_wdata[0];
    assign bus0.req_sl_type = t_req_sl[0];
    assign bus0.rsp_ready   = t_rsp_ready[0];
    assign t_req_ready[0]   = bus0.req_ready;
    assign t_rsp_valid[0]   = bus0.rsp_valid;
    assign t_rsp_rdata[0]   = bus0.rsp_rdata;
    assign t_rsp_err[0]     = bus0.rsp_err;

    assign bus3.req_valid   = t_req_valid[1];
    assign bus3.req_we      = t_req_we[1];
    assign bus3.req_addr    = t_req_addr[1];
    assign bus3.req_wdata   = t_req_wdata[1];
    assign bus3.req_sl_type = t_req_sl[1];
    assign bus3.rsp_ready   = t_rsp_ready[1];
    assign t_req_ready[1]   = bus3.req_ready;
    assign t_rsp_valid[1]   = bus3.rsp_valid;
    assign t_rsp_rdata[1]   = bus3.rsp_rdata;
    assign t_rsp_err[1]     = bus3.rsp_err;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .bus(bus0)
    );
    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .ADDR_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n[1]), .bus(bus3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic note_timeout(input string name);
        n_total++;
        $display("FAIL %s: got no handshake within the cycle budget, required a handshake", name);
    endtask

    // Called and returns at a negedge; returns when the response is visible.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sl,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int acc_cyc);
        int guard = 0;
        t_req_we[d] = we; t_req_addr[d] = addr; t_req_wdata[d] = wdata;
        t_req_sl[d] = sl; t_req_valid[d] = 1'b1; t_rsp_ready[d] = 1'b1;
        while (!t_req_ready[d] && guard < 20) begin @(negedge clk); guard++; end
        if (!t_req_ready[d]) note_timeout("req_ready_wait");
        acc_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        t_req_valid[d] = 1'b0;
        lat = 1;
        while (!t_rsp_valid[d] && lat < 40) begin @(negedge clk); lat++; end
        if (!t_rsp_valid[d]) note_timeout("rsp_valid_wait");
        rdata = t_rsp_rdata[d];
        err   = t_rsp_err[d];
    endtask

    function automatic int mkey(input int d, input logic [31:0] a);
        return (d << 28) | int'({4'b0000, a[27:0]});
    endfunction

    // Reference: byte-addressed little-endian memory, rules straight from the access definition.
    function automatic void model_access(input int d, input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] sl,
                                         output logic [31:0] rd, output logic err);
        int nbytes;
        logic [31:0] val;
        nbytes = (sl[1:0] == 2'b00) ? 1 : (sl[1:0] == 2'b01) ? 2 : (sl[1:0] == 2'b10) ? 4 : 0;
        err = sl[3] || (nbytes == 0) || ((nbytes != 0) && (addr % nbytes != 0)) || ((addr >> 2) >= DEPTH);
        rd = 32'd0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < nbytes; i++) model[mkey(d, addr + i)] = 8'(wdata >> (8 * i));
        end else begin
            val = 32'd0;
            for (int i = 0; i < nbytes; i++) val = val | (32'(model[mkey(d, addr + i)]) << (8 * i));
            if (!sl[2] && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
            rd = val;
        end
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd, exp_rd, wd, ad;
        logic        er, exp_er, we;
        logic [3:0]  sl;
        int          lat, acc, acc_prev, guard, d;

        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; t_req_valid[i] = 1'b0; t_req_we[i] = 1'b0;
            t_req_addr[i] = '0; t_req_wdata[i] = '0; t_req_sl[i] = '0; t_rsp_ready[i] = 1'b1;
        end

        // Reset state.
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_rsp_valid", i), 32'(t_rsp_valid[i]), 32'd0);
            check($sformatf("rst%0d_rsp_rdata", i), t_rsp_rdata[i], 32'd0);
            check($sformatf("rst%0d_rsp_err", i), 32'(t_rsp_err[i]), 32'd0);
            check($sformatf("rst%0d_req_ready", i), 32'(t_req_ready[i]), 32'd1);
        end
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);

        // Directed vectors on the zero-wait instance.
        vecs.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0010, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h100, 32'h0,         4'b0010, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h101, 32'h0000_0080, 4'b0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h101, 32'h0,         4'b0000, 32'hFFFF_FF80, 1'b0});
        vecs.push_back('{1'b0, 32'h101, 32'h0,         4'b0100, 32'h0000_0080, 1'b0});
        vecs.push_back('{1'b0, 32'h100, 32'h0,         4'b0010, 32'hDEAD_80EF, 1'b0});
        vecs.push_back('{1'b1, 32'h102, 32'h0000_1234, 4'b0001, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h100, 32'h0,         4'b0010, 32'h1234_80EF, 1'b0});
        vecs.push_back('{1'b0, 32'h103, 32'h0,         4'b0001, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 32'h102, 32'hFFFF_FFFF, 4'b0010, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h100, 32'h0,         4'b0010, 32'h1234_80EF, 1'b0});
        vecs.push_back('{1'b0, 32'h100, 32'h0,         4'b0011, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h4_0000, 32'h0,      4'b0010, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h100, 32'h0,         4'b1010, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h102, 32'h0,         4'b0001, 32'h0000_1234, 1'b0});
        vecs.push_back('{1'b0, 32'h100, 32'h0,         4'b0001, 32'hFFFF_80EF, 1'b0});
        vecs.push_back('{1'b0, 32'h100, 32'h0,         4'b0101, 32'h0000_80EF, 1'b0});
        vecs.push_back('{1'b1, 32'h103, 32'hABCD_EF7F, 4'b0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 32'h100, 32'h5555_5555, 4'b0011, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h100, 32'h0,         4'b0010, 32'h7F34_80EF, 1'b0});
        vecs.push_back('{1'b0, 32'h103, 32'h0,         4'b0000, 32'h0000_007F, 1'b0});
        foreach (vecs[i]) begin
            txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sl, rd, er, lat, acc);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
        end

        // Back-to-back throughput: N+2 cycles between accepts.
        txn(0, 1'b0, 32'h100, 32'h0, 4'b0010, rd, er, lat, acc_prev);
        txn(0, 1'b0, 32'h100, 32'h0, 4'b0010, rd, er, lat, acc);
        check("thru0_spacing", 32'(acc - acc_prev), 32'd2);
        txn(1, 1'b1, 32'h300, 32'h5A5A_A5A5, 4'b0010, rd, er, lat, acc_prev);
        check("w3_store_latency", 32'(lat), 32'd4);
        txn(1, 1'b0, 32'h300, 32'h0, 4'b0010, rd, er, lat, acc);
        check("thru3_spacing", 32'(acc - acc_prev), 32'd5);
        check("w3_load_rdata", rd, 32'h5A5A_A5A5);

        // Backpressure on the 3-wait instance; a pending request must be ignored.
        t_req_we[1] = 1'b0; t_req_addr[1] = 32'h300; t_req_sl[1] = 4'b0010; t_req_valid[1] = 1'b1;
        guard = 0;
        while (!t_req_ready[1] && guard < 20) begin @(negedge clk); guard++; end
        if (!t_req_ready[1]) note_timeout("bp_accept_wait");
        t_rsp_ready[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        t_req_we[1] = 1'b1; t_req_wdata[1] = 32'hFFFF_FFFF;
        lat = 1;
        while (!t_rsp_valid[1] && lat < 40) begin @(negedge clk); lat++; end
        check("bp_latency", 32'(lat), 32'd4);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_rsp_valid", k), 32'(t_rsp_valid[1]), 32'd1);
            check($sformatf("bp%0d_rdata", k), t_rsp_rdata[1], 32'h5A5A_A5A5);
            check($sformatf("bp%0d_req_ready", k), 32'(t_req_ready[1]), 32'd0);
            @(negedge clk);
        end
        t_rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_release_rsp_valid", 32'(t_rsp_valid[1]), 32'd0);
        check("bp_release_req_ready", 32'(t_req_ready[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        t_req_valid[1] = 1'b0;
        lat = 1;
        while (!t_rsp_valid[1] && lat < 40) begin @(negedge clk); lat++; end
        check("bp_next_latency", 32'(lat), 32'd4);
        check("bp_next_err", 32'(t_rsp_err[1]), 32'd0);
        check("bp_next_rdata", t_rsp_rdata[1], 32'd0);
        txn(1, 1'b0, 32'h300, 32'h0, 4'b0010, rd, er, lat, acc);
        check("bp_after_store", rd, 32'hFFFF_FFFF);

        // Reset during WAIT aborts an uncommitted store.
        txn(1, 1'b1, 32'h200, 32'h1122_3344, 4'b0010, rd, er, lat, acc);
        t_req_we[1] = 1'b1; t_req_addr[1] = 32'h200; t_req_wdata[1] = 32'hAAAA_AAAA;
        t_req_sl[1] = 4'b0010; t_req_valid[1] = 1'b1;
        guard = 0;
        while (!t_req_ready[1] && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        #1 t_req_valid[1] = 1'b0;
        @(posedge clk);
        #2 rst_n[1] = 1'b0;
        #1;
        check("rstA_req_ready_async", 32'(t_req_ready[1]), 32'd1);
        check("rstA_rsp_valid", 32'(t_rsp_valid[1]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b1;

        // Reset during RESP drops the response immediately.
        t_req_we[1] = 1'b0; t_req_addr[1] = 32'h200; t_req_sl[1] = 4'b0010;
        t_req_valid[1] = 1'b1; t_rsp_ready[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        t_req_valid[1] = 1'b0;
        lat = 1;
        while (!t_rsp_valid[1] && lat < 40) begin @(negedge clk); lat++; end
        check("rstB_rdata_before", t_rsp_rdata[1], 32'h1122_3344);
        #2 rst_n[1] = 1'b0;
        #1;
        check("rstB_rsp_valid_async", 32'(t_rsp_valid[1]), 32'd0);
        check("rstB_rsp_rdata_async", t_rsp_rdata[1], 32'd0);
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b1;
        t_rsp_ready[1] = 1'b1;
        @(negedge clk);
        txn(1, 1'b0, 32'h200, 32'h0, 4'b0010, rd, er, lat, acc);
        check("rst_store_aborted", rd, 32'h1122_3344);

        // Random traffic against the reference model.
        for (int dd = 0; dd < 2; dd++) begin
            for (int w = 0; w < 16; w++) begin
                wd = $urandom;
                model_access(dd, 1'b1, 32'h1000 + 32'(4 * w), wd, 4'b0010, exp_rd, exp_er);
                txn(dd, 1'b1, 32'h1000 + 32'(4 * w), wd, 4'b0010, rd, er, lat, acc);
                check($sformatf("init%0d_%0d_err", dd, w), 32'(er), 32'(exp_er));
            end
        end
        for (int n = 0; n < 120; n++) begin
            d  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            ad = 32'h1000 + 32'($urandom_range(0, 63));
            sl = {1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 15) == 0) sl[3] = 1'b1;
            if ($urandom_range(0, 15) == 0) ad = 32'h4_0000 + 32'(4 * $urandom_range(0, 1000));
            wd = $urandom;
            model_access(d, we, ad, wd, sl, exp_rd, exp_er);
            txn(d, we, ad, wd, sl, rd, er, lat, acc);
            check($sformatf("rnd%0d_rdata d%0d a%08h sl%04b we%0d", n, d, ad, sl, we), rd, exp_rd);
            check($sformatf("rnd%0d_err", n), 32'(er), 32'(exp_er));
            check($sformatf("rnd%0d_latency", n), 32'(lat), (d == 0) ? 32'd1 : 32'd4);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
